cb_register_file: RTL and testbench

Parametrised multi-register storage block for the 8-bit CPU datapath, generalising the single clear/load register into a bank of DEPTH registers of WIDTH bits. It provides one synchronous write port, two combinational read ports with write-through bypass, and a multi-cycle flush sequencer that zeroes the bank one entry per cycle while signalling busy. It sits between the control unit and the ALU/bus, replacing discrete A/B/general-purpose register instances.

---
 rtl/cb_register_file.sv | 95 +++++++++
 tb/tb_cb_register_file.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cb_register_file.sv
// Bank of DEPTH registers with one write port, two bypassed combinational read
// ports, and a flush sequencer that zeroes one entry per cycle while busy.
module cb_register_file #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             flush,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy,
    output logic             wr_drop
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             wr_drop_q, wr_drop_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             wr_ok;

    // A write lands only when the sequencer is idle and not about to start.
    assign wr_ok = we && (state_q == IDLE) && !flush;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        regs_d    = regs_q;
        wr_drop_d = we && !wr_ok;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                regs_d[idx_q] = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        if (wr_ok) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wr_drop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_drop_q <= wr_drop_d;
            regs_q    <= regs_d;
        end
    end

    // Bypass only forwards writes that will actually commit at this edge.
    assign rdata_a = (wr_ok && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
    assign rdata_b = (wr_ok && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];

    assign busy    = (state_q == SWEEP);
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_cb_register_file.sv
// Table-driven bench for cb_register_file (WIDTH=8, DEPTH=4); expectations are
// queued as each vector is driven and popped when outputs are sampled.
module tb_cb_register_file;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       flush;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] raddr_a;
    logic [7:0] rdata_a;
    logic [1:0] raddr_b;
    logic [7:0] rdata_b;
    logic       busy;
    logic       wr_drop;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       we;
        logic [1:0] waddr;
        logic [7:0] wdata;
        logic       flush;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ebusy;
        logic       edrop;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    cb_register_file #(.WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .flush   (flush),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b),
        .busy    (busy),
        .wr_drop (wr_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic w, logic [1:0] wa, logic [7:0] wd, logic fl,
                                logic [1:0] ra, logic [1:0] rb, logic [7:0] ea,
                                logic [7:0] eb, logic eby, logic edr);
        vec_t v;
        v.we = w;  v.waddr = wa; v.wdata = wd; v.flush = fl;
        v.ra = ra; v.rb = rb;    v.ea = ea;    v.eb = eb;
        v.ebusy = eby; v.edrop = edr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic compare_front(input int idx);
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard[%0d]: queue empty, got 1 expected entry", idx);
            return;
        end
        e = sb.pop_front();
        chk("rdata_a", idx, rdata_a, e.ea);
        chk("rdata_b", idx, rdata_b, e.eb);
        chk("busy",    idx, {7'd0, busy},    {7'd0, e.ebusy});
        chk("wr_drop", idx, {7'd0, wr_drop}, {7'd0, e.edrop});
    endtask

    // Called at a negedge: drive, let combinational paths settle, check, advance.
    task automatic step(input vec_t v, input int idx);
        we      = v.we;
        waddr   = v.waddr;
        wdata   = v.wdata;
        flush   = v.flush;
        raddr_a = v.ra;
        raddr_b = v.rb;
        sb.push_back(v);
        #2;
        compare_front(idx);
        @(negedge clk);
    endtask

    initial begin
        clear_n = 1'b0;
        flush = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;

        // Reset state: every entry zero, no busy, no drop.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            raddr_a = 2'(i);
            raddr_b = 2'(3 - i);
            sb.push_back(mk(0, 0, 0, 0, 2'(i), 2'(3 - i), 8'h00, 8'h00, 0, 0));
            #1;
            compare_front(100 + i);
        end
        @(negedge clk);
        clear_n = 1'b1;

        // load/hold, bypass, bank load, flush sweep with dropped writes
        tbl.push_back(mk(1, 2, 8'hA5, 0, 2, 0, 8'hA5, 8'h00, 0, 0));
        tbl.push_back(mk(0, 2, 8'hFF, 0, 2, 1, 8'hA5, 8'h00, 0, 0));
        tbl.push_back(mk(0, 2, 8'hFF, 0, 3, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 8'h3C, 0, 1, 0, 8'h3C, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 2, 8'h3C, 8'hA5, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 2, 2, 8'hA5, 8'hA5, 0, 0));
        tbl.push_back(mk(1, 0, 8'h11, 0, 0, 3, 8'h11, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 8'h22, 0, 1, 0, 8'h22, 8'h11, 0, 0));
        tbl.push_back(mk(1, 2, 8'h33, 0, 2, 1, 8'h33, 8'h22, 0, 0));
        tbl.push_back(mk(1, 3, 8'h44, 0, 3, 2, 8'h44, 8'h33, 0, 0));
        tbl.push_back(mk(1, 3, 8'h77, 1, 3, 0, 8'h44, 8'h11, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h11, 8'h22, 1, 1));
        tbl.push_back(mk(1, 3, 8'h77, 0, 0, 3, 8'h00, 8'h44, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 2, 8'h00, 8'h33, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 2, 3, 8'h00, 8'h44, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 3, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 2, 8'h5C, 0, 2, 3, 8'h5C, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 2, 1, 8'h5C, 8'h00, 0, 0));
        // flush held six cycles: two sweeps with one idle cycle between,
        // plus back-to-back dropped writes in the second sweep
        tbl.push_back(mk(0, 0, 8'h00, 1, 2, 0, 8'h5C, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2, 0, 8'h5C, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2, 0, 8'h5C, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2, 0, 8'h5C, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 2, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 8'h99, 0, 2, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 8'h99, 0, 2, 0, 8'h00, 8'h00, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 2, 0, 8'h00, 8'h00, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0));

        foreach (tbl[i]) step(tbl[i], i);

        // Reset mid-sweep: a pending drop and busy must vanish at once.
        step(mk(1, 3, 8'h44, 0, 3, 0, 8'h44, 8'h00, 0, 0), 200);
        step(mk(0, 0, 8'h00, 1, 3, 0, 8'h44, 8'h00, 0, 0), 201);
        step(mk(1, 1, 8'h12, 0, 3, 1, 8'h44, 8'h00, 1, 0), 202);
        we = 1'b0; flush = 1'b0; raddr_a = 2'd3; raddr_b = 2'd0;
        sb.push_back(mk(0, 0, 8'h00, 0, 3, 0, 8'h44, 8'h00, 1, 1));
        #1;
        compare_front(203);
        #1;
        clear_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            raddr_a = 2'(i);
            raddr_b = 2'(3 - i);
            sb.push_back(mk(0, 0, 8'h00, 0, 2'(i), 2'(3 - i), 8'h00, 8'h00, 0, 0));
            #1;
            compare_front(204 + i);
        end
        @(negedge clk);
        clear_n = 1'b1;
        step(mk(1, 3, 8'h5A, 0, 3, 0, 8'h5A, 8'h00, 0, 0), 210);
        step(mk(0, 0, 8'h00, 0, 3, 3, 8'h5A, 8'h5A, 0, 0), 211);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
